// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer among NREQ byte sources.
// Optional stalled-frame abort is compiled in with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 200000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    tx_start,
    output logic [DW-1:0]           tx_din,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    timeout_err
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic [IW-1:0] grant;
    logic          hit;
    logic          expired;
    logic          cooldown;

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 2) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    // Round-robin search: first requester after ptr, wrapping modulo NREQ.
    always_comb begin
        grant = '0;
        hit   = 1'b0;
        cand  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!hit && req[cand]) begin
                grant = cand;
                hit   = 1'b1;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign expired = (cnt == CW'(TIMEOUT - 1));
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // The cycle a completion or abort is reported is spent in IDLE without
    // arbitrating, so the next launch comes two cycles after that report.
    assign cooldown = (|done) || timeout_err;

    // Arbitration FSM with registered handshake pulses and latched byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IW'(NREQ - 1);
            owner    <= '0;
            tx_din   <= '0;
            ack      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            cnt         <= (state == WAIT) ? cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: begin
                    if (hit && !cooldown) begin
                        owner    <= grant;
                        tx_din   <= req_data[grant*DW +: DW];
                        ack      <= NREQ'(1) << grant;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (tx_done_tick || expired) begin
                        done  <= tx_done_tick ? (NREQ'(1) << owner) : '0;
                        ptr   <= owner;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        timeout_err <= !tx_done_tick;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
